// File: rtl/univ_shift_reg.sv
// ============================================================================
// univ_shift_reg
// ----------------------------------------------------------------------------
// Purpose:
//   WIDTH-bit universal register. On each enabled clock edge it can hold,
//   parallel-load, shift left/right with serial fill, rotate left/right,
//   arithmetic-shift right or clear. It also has an auto-burst mode: a start
//   request latches one shift/rotate op and a length, and the register then
//   applies that op for LEN consecutive enabled edges. A one-cycle done pulse
//   marks the end of the burst.
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   CNT_W      width of the burst length and remaining-count fields
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active-high; overrides en/start
//   en         in   1       clock enable; 0 freezes q, sout, FSM and counter
//   mode       in   3       000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//                           100 ROL, 101 ROR, 110 ASR, 111 CLR
//   d          in   WIDTH   parallel load data (LOAD)
//   sin        in   1       serial input (SHL fills bit 0, SHR fills the MSB)
//   start      in   1       begin a burst with the current mode and len
//   len        in   CNT_W   burst shift count (0 produces only a done pulse)
//   q          out  WIDTH   register contents
//   sout       out  1       bit shifted out by the most recent shift/rotate
//   busy       out  1       burst in progress
//   done       out  1       one-cycle pulse at burst completion
//   shift_cnt  out  CNT_W   shifts remaining in the current burst
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    // ------------------------------------------------------------------------
    // Operation encoding and FSM states
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    // ------------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------------
    state_e           state_q,     state_d;
    op_e              op_q,        op_d;        // op latched for the burst
    logic [WIDTH-1:0] reg_q,       reg_d;
    logic             sout_q,      sout_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------

    // Only the shift/rotate family (SHL..ASR) may be run as a burst.
    function automatic logic is_burst_op(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

    // Register contents after one application of op.
    function automatic logic [WIDTH-1:0] apply_op(
        input op_e              op,
        input logic [WIDTH-1:0] cur,
        input logic             s_in,
        input logic [WIDTH-1:0] load_val
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            OP_HOLD: res = cur;
            OP_LOAD: res = load_val;
            OP_SHL:  res = {cur[WIDTH-2:0], s_in};
            OP_SHR:  res = {s_in, cur[WIDTH-1:1]};
            OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_CLR:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Serial output after one application of op. Left-moving ops expose the
    // old MSB, right-moving ops the old LSB; non-shift ops keep the last value
    // so sout always reflects the most recent bit actually shifted out.
    function automatic logic apply_sout(
        input op_e              op,
        input logic [WIDTH-1:0] cur,
        input logic             old_sout
    );
        logic res;
        res = old_sout;
        case (op)
            OP_SHL, OP_ROL:         res = cur[WIDTH-1];
            OP_SHR, OP_ROR, OP_ASR: res = cur[0];
            default:                res = old_sout;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        reg_d       = reg_q;
        sout_d      = sout_q;
        busy_d      = busy_q;
        shift_cnt_d = shift_cnt_q;
        // done defaults low every edge, enabled or not, so it is always a
        // single-cycle pulse.
        done_d      = 1'b0;

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_burst_op(op_e'(mode))) begin
                        // Register is untouched on the start edge; shifting
                        // begins on the following enabled edge.
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            op_d        = op_e'(mode);
                            shift_cnt_d = len;
                            busy_d      = 1'b1;
                            state_d     = ST_SHIFT;
                        end
                    end else begin
                        // Plain single op; start is ignored for HOLD/LOAD/CLR.
                        reg_d  = apply_op(op_e'(mode), reg_q, sin, d);
                        sout_d = apply_sout(op_e'(mode), reg_q, sout_q);
                    end
                end

                ST_SHIFT: begin
                    // External mode/start are ignored; sin is still live.
                    reg_d       = apply_op(op_q, reg_q, sin, d);
                    sout_d      = apply_sout(op_q, reg_q, sout_q);
                    shift_cnt_d = shift_cnt_q - CNT_W'(1);
                    if (shift_cnt_q == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers (synchronous reset aborts any burst without done)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_HOLD;
            reg_q       <= '0;
            sout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shift_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            reg_q       <= reg_d;
            sout_q      <= sout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are driven straight from flops
    // ------------------------------------------------------------------------
    assign q         = reg_q;
    assign sout      = sout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_cnt = shift_cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// tb_univ_shift_reg
// ----------------------------------------------------------------------------
// Directed bench for univ_shift_reg (WIDTH=8). Each stimulus step drives one
// cycle of inputs and pushes the hand-computed register state expected after
// the next rising edge onto a scoreboard queue. A separate monitor samples the
// DUT shortly after every rising edge and checks the entries due that cycle.
// ============================================================================
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shift_cnt;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin       (sin),
        .start     (start),
        .len       (len),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done),
        .shift_cnt (shift_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        string            name;
        logic [WIDTH-1:0] q;
        logic             sout;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every scoreboard entry due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check({e.name, ".q"},         32'(q),         32'(e.q));
                check({e.name, ".sout"},      32'(sout),      32'(e.sout));
                check({e.name, ".busy"},      32'(busy),      32'(e.busy));
                check({e.name, ".done"},      32'(done),      32'(e.done));
                check({e.name, ".shift_cnt"}, 32'(shift_cnt), 32'(e.cnt));
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after that edge.
    task automatic step(
        input logic             r,
        input logic             e_n,
        input logic [2:0]       m,
        input logic [WIDTH-1:0] dd,
        input logic             s,
        input logic             st,
        input logic [CNT_W-1:0] l,
        input string            nm,
        input logic [WIDTH-1:0] eq,
        input logic             es,
        input logic             eb,
        input logic             ed,
        input logic [CNT_W-1:0] ec
    );
        exp_t x;
        @(negedge clk);
        rst   = r;
        en    = e_n;
        mode  = m;
        d     = dd;
        sin   = s;
        start = st;
        len   = l;
        x.cyc  = cyc + 1;
        x.name = nm;
        x.q    = eq;
        x.sout = es;
        x.busy = eb;
        x.done = ed;
        x.cnt  = ec;
        sb.push_back(x);
    endtask

    initial begin
        logic [WIDTH-1:0] one;
        rst = 1'b1; en = 1'b1; mode = M_LOAD; d = 8'hA5;
        sin = 1'b0; start = 1'b0; len = '0;

        //    rst en mode    d      sin st len  name          q      so bs dn cnt
        // Reset dominates a LOAD.
        step(1, 1, M_LOAD, 8'hA5, 0, 0, 0, "reset0",      8'h00, 0, 0, 0, 0);
        step(1, 1, M_LOAD, 8'hA5, 0, 1, 3, "reset1",      8'h00, 0, 0, 0, 0);

        // Basic ops.
        step(0, 1, M_LOAD, 8'hA5, 0, 0, 0, "load_a5",     8'hA5, 0, 0, 0, 0);
        step(0, 1, M_SHL,  8'h00, 1, 0, 0, "shl",         8'h4B, 1, 0, 0, 0);
        step(0, 1, M_SHR,  8'h00, 0, 0, 0, "shr",         8'h25, 1, 0, 0, 0);
        step(0, 1, M_CLR,  8'hFF, 0, 0, 0, "clr",         8'h00, 1, 0, 0, 0);
        step(0, 1, M_HOLD, 8'hFF, 1, 0, 0, "hold",        8'h00, 1, 0, 0, 0);

        // Rotates and arithmetic shift.
        step(0, 1, M_LOAD, 8'h81, 0, 0, 0, "load_81a",    8'h81, 1, 0, 0, 0);
        step(0, 1, M_ROR,  8'h00, 0, 0, 0, "ror",         8'hC0, 1, 0, 0, 0);
        step(0, 1, M_LOAD, 8'h80, 0, 0, 0, "load_80",     8'h80, 1, 0, 0, 0);
        step(0, 1, M_ASR,  8'h00, 0, 0, 0, "asr",         8'hC0, 0, 0, 0, 0);
        step(0, 1, M_LOAD, 8'h81, 0, 0, 0, "load_81b",    8'h81, 0, 0, 0, 0);
        step(0, 1, M_ROL,  8'h00, 0, 0, 0, "rol",         8'h03, 1, 0, 0, 0);

        // ROL burst of 3; mode flips to CLR mid-burst and must be ignored.
        step(0, 1, M_LOAD, 8'h01, 0, 0, 0, "load_01",     8'h01, 1, 0, 0, 0);
        step(0, 1, M_ROL,  8'h00, 0, 1, 3, "b3_start",    8'h01, 1, 1, 0, 3);
        step(0, 1, M_CLR,  8'h00, 0, 0, 0, "b3_s1",       8'h02, 0, 1, 0, 2);
        step(0, 1, M_CLR,  8'h00, 0, 0, 0, "b3_s2",       8'h04, 0, 1, 0, 1);
        step(0, 1, M_CLR,  8'h00, 0, 0, 0, "b3_s3",       8'h08, 0, 0, 1, 0);
        step(0, 1, M_HOLD, 8'h00, 0, 0, 0, "b3_after",    8'h08, 0, 0, 0, 0);

        // SHL burst of 4 with sin=1 and two disabled cycles in the middle.
        step(0, 1, M_SHL,  8'h00, 1, 1, 4, "b4_start",    8'h08, 0, 1, 0, 4);
        step(0, 1, M_HOLD, 8'h00, 1, 0, 0, "b4_s1",       8'h11, 0, 1, 0, 3);
        step(0, 0, M_CLR,  8'h00, 1, 1, 0, "b4_frz1",     8'h11, 0, 1, 0, 3);
        step(0, 0, M_CLR,  8'h00, 1, 0, 0, "b4_frz2",     8'h11, 0, 1, 0, 3);
        step(0, 1, M_HOLD, 8'h00, 1, 0, 0, "b4_s2",       8'h23, 0, 1, 0, 2);
        step(0, 1, M_HOLD, 8'h00, 1, 0, 0, "b4_s3",       8'h47, 0, 1, 0, 1);
        step(0, 1, M_HOLD, 8'h00, 1, 0, 0, "b4_s4",       8'h8F, 0, 0, 1, 0);
        // done clears even while disabled.
        step(0, 0, M_HOLD, 8'h00, 0, 0, 0, "b4_done_clr", 8'h8F, 0, 0, 0, 0);

        // Zero-length start: done only, register untouched.
        step(0, 1, M_SHL,  8'h00, 1, 1, 0, "len0",        8'h8F, 0, 0, 1, 0);
        step(0, 1, M_HOLD, 8'h00, 0, 0, 0, "len0_after",  8'h8F, 0, 0, 0, 0);

        // Start with a non-shift mode just executes that mode.
        step(0, 1, M_LOAD, 8'h3C, 0, 1, 5, "start_load",  8'h3C, 0, 0, 0, 0);
        step(0, 1, M_LOAD, 8'h8F, 0, 0, 0, "reload_8f",   8'h8F, 0, 0, 0, 0);

        // SHR burst aborted by reset; a start while busy is ignored.
        step(0, 1, M_SHR,  8'h00, 0, 1, 4, "ab_start",    8'h8F, 0, 1, 0, 4);
        step(0, 1, M_HOLD, 8'h00, 0, 0, 0, "ab_s1",       8'h47, 1, 1, 0, 3);
        step(0, 1, M_LOAD, 8'hFF, 0, 1, 0, "ab_s2_start", 8'h23, 1, 1, 0, 2);
        step(1, 1, M_HOLD, 8'h00, 0, 0, 0, "ab_rst",      8'h00, 0, 0, 0, 0);
        step(0, 1, M_HOLD, 8'h00, 0, 0, 0, "ab_nodone",   8'h00, 0, 0, 0, 0);

        // Burst longer than WIDTH: 9 rotates of 01 wrap around to 02.
        step(0, 1, M_LOAD, 8'h01, 0, 0, 0, "load_01b",    8'h01, 0, 0, 0, 0);
        step(0, 1, M_ROL,  8'h00, 0, 1, 9, "b9_start",    8'h01, 0, 1, 0, 9);
        for (int k = 0; k < 9; k++) begin
            one = 8'h01;
            step(0, 1, M_HOLD, 8'h00, 0, 0, 0, $sformatf("b9_s%0d", k + 1),
                 one << ((k + 1) % 8), (k == 7), (k != 8), (k == 8),
                 CNT_W'(8 - k));
        end
        step(0, 1, M_HOLD, 8'h00, 0, 0, 0, "b9_after",    8'h02, 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded.
        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (sb.size() > 0) begin
                compared++;
                mismatched++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
